// File: rtl/ctrl_mc_fsm.sv
// ctrl_mc_fsm: multi-cycle FETCH/DEC/EXEC/MEM control sequencer for the 16-bit WISC core.
// Decoded controls are registered in DEC and only exposed while in EXEC or MEM.
module ctrl_mc_fsm #(
    parameter int ALU_W      = 5,
    parameter int MULTICYCLE = 1,
    parameter int MEM_TO     = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [4:0]       instr_op,
    output logic             instr_rdy,
    input  logic             Zflag,
    input  logic             Sflag,
    input  logic             mem_done,
    output logic             RegWrite,
    output logic             PcSel,
    output logic             Pc2Reg,
    output logic             MemEnable,
    output logic             MemWr,
    output logic             Val2Reg,
    output logic             ALUSel,
    output logic [2:0]       ImmSel,
    output logic [1:0]       LinkReg,
    output logic [ALU_W-1:0] ALUcntrl,
    output logic             PcWrite,
    output logic             Halt,
    output logic             err,
    output logic [CNT_W-1:0] retired
);
    localparam int TW = $clog2(MEM_TO + 1);

    typedef enum logic [2:0] {FETCH, DEC, EXEC, MEM, HALTED} state_t;

    typedef struct packed {
        logic             rw;
        logic             jmp;
        logic             br;
        logic             pc2reg;
        logic             alusel;
        logic             val2reg;
        logic             ld;
        logic             wr;
        logic             mem;
        logic             halt;
        logic [2:0]       imm;
        logic [1:0]       link;
        logic [ALU_W-1:0] alu;
    } ctl_t;

    function automatic ctl_t decode(input logic [4:0] op);
        ctl_t c;
        c = '0;
        c.alu = ALU_W'(op);
        casez (op)
            5'b00000: c.halt = 1'b1;
            5'b001??: begin
                c.jmp    = 1'b1;
                c.alusel = 1'b1;
                c.alu    = ALU_W'(5'b01000);
                c.imm    = op[0] ? 3'b101 : 3'b110;
                c.rw     = op[1];
                c.pc2reg = op[1];
                c.link   = op[1] ? 2'b11 : 2'b00;
            end
            5'b010??, 5'b101??: begin
                c.rw     = 1'b1;
                c.alusel = 1'b1;
                c.link   = 2'b01;
                c.imm    = op[1] ? 3'b000 : 3'b100;
            end
            5'b011??: begin
                c.br  = 1'b1;
                c.imm = 3'b101;
            end
            5'b10000, 5'b10001, 5'b10011: begin
                c.mem     = 1'b1;
                c.alusel  = 1'b1;
                c.alu     = ALU_W'(5'b01000);
                c.imm     = 3'b100;
                c.ld      = ~op[1] & op[0];
                c.wr      = ~(~op[1] & op[0]);
                c.val2reg = ~op[1] & op[0];
                c.rw      = op[0];
                c.link    = op[1] ? 2'b10 : {1'b0, op[0]};
            end
            5'b10010, 5'b11000: begin
                c.rw     = 1'b1;
                c.alusel = 1'b1;
                c.link   = 2'b10;
                c.imm    = op[3] ? 3'b101 : 3'b001;
            end
            5'b11001, 5'b1101?, 5'b111??: c.rw = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [4:0]       op_q, op_d;
    ctl_t             ctl_q, ctl_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic ex, mm, act, done, timeout, cond;

    assign ex      = state_q == EXEC;
    assign mm      = state_q == MEM;
    assign act     = ex | mm;
    assign done    = (MULTICYCLE == 0) | mem_done;
    assign timeout = cnt_q == TW'(MEM_TO - 1);
    // op[0] inverts the flag; op[1] picks sign over zero
    assign cond    = (op_q[1] ? Sflag : Zflag) ^ op_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            rdy_q     <= 1'b0;
            op_q      <= '0;
            ctl_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            op_q      <= op_d;
            ctl_q     <= ctl_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ctl_d     = ctl_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        retired_d = retired_q + CNT_W'(PcWrite);
        case (state_q)
            FETCH: if (rdy_q && instr_valid) begin
                op_d    = instr_op;
                state_d = DEC;
            end
            DEC: begin
                ctl_d   = decode(op_q);
                state_d = EXEC;
            end
            EXEC: begin
                cnt_d   = '0;
                state_d = ctl_q.halt ? HALTED : ctl_q.mem ? MEM : FETCH;
            end
            MEM: begin
                cnt_d = cnt_q + TW'(1);
                if (done) state_d = FETCH;
                else if (timeout) begin
                    state_d = HALTED;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
        rdy_d = state_d == FETCH;
    end

    always_comb begin
        instr_rdy = rdy_q;
        RegWrite  = ctl_q.rw & ((ex & ~ctl_q.mem) | (mm & done));
        PcSel     = ex & (ctl_q.jmp | (ctl_q.br & cond));
        Pc2Reg    = ex & ctl_q.pc2reg;
        MemEnable = mm & ctl_q.ld;
        MemWr     = mm & ctl_q.wr;
        Val2Reg   = mm & done & ctl_q.val2reg;
        ALUSel    = act & ctl_q.alusel;
        ImmSel    = act ? ctl_q.imm : 3'b000;
        LinkReg   = act ? ctl_q.link : 2'b00;
        ALUcntrl  = act ? ctl_q.alu : '0;
        PcWrite   = (ex & ~ctl_q.mem & ~ctl_q.halt) | (mm & done);
        Halt      = state_q == HALTED;
        err       = err_q;
        retired   = retired_q;
    end
endmodule

// File: tb/tb_ctrl_mc_fsm.sv
// tb_ctrl_mc_fsm: random opcode streams and directed corner cases checked cycle by cycle
// against an opcode-level reference model of the control unit.
module tb_ctrl_mc_fsm;
    localparam int CW = 4;
    localparam int TO = 15;

    logic clk = 1'b0, rst = 1'b0, instr_valid = 1'b0, Zflag = 1'b0, Sflag = 1'b0, mem_done = 1'b0;
    logic [4:0] instr_op = '0;
    logic instr_rdy, RegWrite, PcSel, Pc2Reg, MemEnable, MemWr, Val2Reg, ALUSel, PcWrite, Halt, err;
    logic [2:0] ImmSel;
    logic [1:0] LinkReg;
    logic [4:0] ALUcntrl;
    logic [CW-1:0] retired;
    int n_tests = 0, n_fail = 0, ret_m = 0;

    always #5 clk = ~clk;

    ctrl_mc_fsm #(.ALU_W(5), .MULTICYCLE(1), .MEM_TO(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_op(instr_op), .instr_rdy(instr_rdy),
        .Zflag(Zflag), .Sflag(Sflag), .mem_done(mem_done), .RegWrite(RegWrite), .PcSel(PcSel),
        .Pc2Reg(Pc2Reg), .MemEnable(MemEnable), .MemWr(MemWr), .Val2Reg(Val2Reg), .ALUSel(ALUSel),
        .ImmSel(ImmSel), .LinkReg(LinkReg), .ALUcntrl(ALUcntrl), .PcWrite(PcWrite), .Halt(Halt),
        .err(err), .retired(retired)
    );

    wire [20:0] obs = {instr_rdy, RegWrite, PcSel, Pc2Reg, MemEnable, MemWr, Val2Reg, ALUSel,
                       ImmSel, LinkReg, ALUcntrl, PcWrite, Halt, err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ph: 0 fetch-accept, 1 decode, 2 execute, 3 memory, 4 halted
    function automatic logic [20:0] model(input logic [4:0] op, input int ph, input bit z,
                                          input bit s, input bit dn, input bit er);
        bit rdy = 0, rw = 0, pcs = 0, p2r = 0, me = 0, mw = 0, v2r = 0, als = 0, pcw = 0, hl = 0, e = 0;
        logic [2:0] imm = 3'd0;
        logic [1:0] lnk = 2'd0;
        logic [4:0] alu = 5'd0;
        int u;
        bit ld, st, stu, memop;
        u = int'(op);
        ld = u == 17;
        st = u == 16;
        stu = u == 19;
        memop = ld | st | stu;
        if (ph == 0) rdy = 1;
        else if (ph == 4) begin
            hl = 1;
            e = er;
        end else if (ph >= 2) begin
            alu = op;
            if ((u >= 8 && u <= 11) || (u >= 20 && u <= 23)) begin
                rw = 1; als = 1; lnk = 2'd1;
                imm = op[1] ? 3'd0 : 3'd4;
            end else if (u >= 12 && u <= 15) begin
                imm = 3'd5;
                pcs = (u == 12) ? z : (u == 13) ? !z : (u == 14) ? s : !s;
            end else if (u >= 4 && u <= 7) begin
                pcs = 1; als = 1; alu = 5'd8;
                imm = op[0] ? 3'd5 : 3'd6;
                if (u >= 6) begin
                    rw = 1; p2r = 1; lnk = 2'd3;
                end
            end else if (memop) begin
                als = 1; alu = 5'd8; imm = 3'd4;
                lnk = ld ? 2'd1 : stu ? 2'd2 : 2'd0;
                if (ph == 3) begin
                    me = ld; mw = !ld;
                    rw = dn && !st;
                    v2r = dn && ld;
                end
            end else if (u == 18 || u == 24) begin
                rw = 1; als = 1; lnk = 2'd2;
                imm = (u == 18) ? 3'd1 : 3'd5;
            end else if (u >= 25) rw = 1;
            pcw = (ph == 2) ? !(memop || u == 0) : dn;
        end
        return {rdy, rw, pcs, p2r, me, mw, v2r, als, imm, lnk, alu, pcw, hl, e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        ret_m = 0;
        chk("rst_outputs", 32'(obs), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4 && !instr_rdy; i++) tick();
        chk("rdy_after_rst", 32'(instr_rdy), 32'd1);
    endtask

    task automatic halted_hold(input bit er);
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1'b1;
            instr_op = 5'($urandom);
            mem_done = 1'($urandom);
            #1;
            chk("halted", 32'(obs), 32'(model(5'd0, 4, 0, 0, 0, er)));
            chk("halted_retired", 32'(retired), 32'(ret_m % 16));
            tick();
        end
        instr_valid = 1'b0;
        mem_done = 1'b0;
    endtask

    // lat: MEM cycle on which mem_done arrives (1-based), 0 = never
    task automatic run(input logic [4:0] op, input int lat, input bit z, input bit s);
        int u;
        bit memop, dn;
        u = int'(op);
        memop = (u == 16 || u == 17 || u == 19);
        instr_valid = 1'b1;
        instr_op = op;
        #1;
        chk("fetch", 32'(obs), 32'(model(op, 0, 0, 0, 0, 0)));
        tick();
        instr_valid = 1'($urandom);
        instr_op = 5'($urandom);
        Zflag = 1'($urandom);
        #1;
        chk("decode", 32'(obs), 32'(model(op, 1, 0, 0, 0, 0)));
        tick();
        instr_valid = 1'b0;
        Zflag = z;
        Sflag = s;
        #1;
        chk($sformatf("exec_op%02h", op), 32'(obs), 32'(model(op, 2, z, s, 0, 0)));
        tick();
        if (u == 0) begin
            halted_hold(0);
            return;
        end
        if (!memop) ret_m++;
        else begin
            for (int k = 0; k < TO; k++) begin
                dn = (lat != 0) && (k == lat - 1);
                mem_done = dn;
                #1;
                chk($sformatf("mem_op%02h_c%0d", op, k), 32'(obs), 32'(model(op, 3, 0, 0, dn, 0)));
                tick();
                mem_done = 1'b0;
                if (dn) begin
                    ret_m++;
                    break;
                end
                if (k == TO - 1) begin
                    halted_hold(1);
                    return;
                end
            end
        end
        chk("retired", 32'(retired), 32'(ret_m % 16));
    endtask

    initial begin
        #2;
        do_reset();
        run(5'b11011, 0, 0, 0);
        run(5'b01101, 0, 1, 0);
        run(5'b01101, 0, 0, 0);
        run(5'b10001, 3, 0, 0);
        for (int i = 0; i < 60; i++)
            run(5'($urandom_range(1, 31)), $urandom_range(1, 4), 1'($urandom), 1'($urandom));
        run(5'b10000, TO, 0, 0);
        run(5'b10000, 0, 0, 0);
        do_reset();
        run(5'b00110, 0, 0, 0);
        run(5'b00000, 0, 0, 0);
        do_reset();
        run(5'b11011, 0, 0, 0);
        run(5'b11011, 0, 0, 0);
        instr_valid = 1'b1;
        instr_op = 5'b10011;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("stu_in_mem", 32'(MemWr), 32'd1);
        #3;
        do_reset();
        run(5'b11011, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
